ysyx_25040111_cache_axi_rd: RTL and testbench

Memory-side responder for the cache refill interface (rstart/raddr/rlen -> rok/rdata). It converts each refill request into one AXI4 INCR read burst on the master read channels (AR/R) and returns each R beat to the cache as a one-cycle rok pulse. A one-deep pending slot absorbs a request that arrives while a burst is still in flight.

---
 rtl/ysyx_25040111_axi_pkg.sv | 15 +
 rtl/ysyx_25040111_cache_axi_rd_if.sv | 27 ++
 rtl/ysyx_25040111_req_slot.sv | 46 ++++
 rtl/ysyx_25040111_cache_axi_rd.sv | 145 ++++++++++++++
 tb/tb_ysyx_25040111_cache_axi_rd.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ysyx_25040111_axi_pkg.sv
// Constants and FSM state type shared by the cache-side AXI read and write paths.
// The encodings are the AXI4 field values the burst engines drive and check.
package ysyx_25040111_axi_pkg;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [2:0] SIZE_4B    = 3'b010;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } rd_state_e;

endpackage

// File: rtl/ysyx_25040111_cache_axi_rd_if.sv
// AXI4 read address and read data channels between the refill engine and memory.
// The master modport is the refill engine; the slave modport is the memory side.
interface ysyx_25040111_cache_axi_rd_if;
    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic [3:0]  rid;

    modport master (
        output arvalid, araddr, arid, arlen, arsize, arburst, rready,
        input  arready, rvalid, rdata, rresp, rlast, rid
    );

    modport slave (
        input  arvalid, araddr, arid, arlen, arsize, arburst, rready,
        output arready, rvalid, rdata, rresp, rlast, rid
    );
endinterface

// File: rtl/ysyx_25040111_req_slot.sv
// One-entry {addr,len} holding register; push wins over pop, so push+pop reloads it.
// Contents are visible the cycle after push; the caller must not push while full without popping.
module ysyx_25040111_req_slot (
    input  logic        clock,
    input  logic        reset,
    input  logic        push_i,
    input  logic        pop_i,
    input  logic [31:0] addr_i,
    input  logic [7:0]  len_i,
    output logic        full_o,
    output logic [31:0] addr_o,
    output logic [7:0]  len_o
);
    logic        full_q, full_d;
    logic [31:0] addr_q, addr_d;
    logic [7:0]  len_q, len_d;

    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        len_d  = len_q;
        if (push_i) begin
            full_d = 1'b1;
            addr_d = addr_i;
            len_d  = len_i;
        end else if (pop_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            full_q <= 1'b0;
            addr_q <= '0;
            len_q  <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
            len_q  <= len_d;
        end
    end

    assign full_o = full_q;
    assign addr_o = addr_q;
    assign len_o  = len_q;
endmodule

// File: rtl/ysyx_25040111_cache_axi_rd.sv
// Cache refill responder: one request becomes one AXI4 INCR read burst; each R beat returns as a rok pulse.
// Request-to-AR 1 cycle, R-handshake-to-rok 1 cycle; one extra request is held while a burst is in flight.
module ysyx_25040111_cache_axi_rd
    import ysyx_25040111_axi_pkg::*;
#(
    parameter logic [3:0]  AXI_ID  = 4'h0,
    parameter int unsigned MAX_LEN = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rstart,
    input  logic [31:0] raddr,
    input  logic [7:0]  rlen,
    output logic        rok,
    output logic [31:0] rdata,
    output logic        busy,
    output logic        err,
    ysyx_25040111_cache_axi_rd_if.master io_master
);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    rd_state_e   state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [7:0]  arlen_q, arlen_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        rok_q, rok_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        slot_push, slot_pop, slot_full;
    logic [31:0] slot_addr;
    logic [7:0]  slot_len;

    logic        r_hs, last_hs, clamp;
    logic [7:0]  req_len;

    assign r_hs    = (state_q == ST_DATA) && io_master.rvalid;
    assign last_hs = r_hs && io_master.rlast;
    assign clamp   = rlen > MAX_LEN_B;
    assign req_len = clamp ? MAX_LEN_B : rlen;

    always_comb begin
        state_d   = state_q;
        araddr_d  = araddr_q;
        arlen_d   = arlen_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        slot_push = 1'b0;
        slot_pop  = 1'b0;
        rok_d     = r_hs;
        rdata_d   = r_hs ? io_master.rdata : rdata_q;

        if (rstart && clamp) err_d = 1'b1;

        // The closing beat's cycle handles rstart itself below, so the slot may be reloaded there.
        if (rstart && (state_q != ST_IDLE) && !last_hs) begin
            if (slot_full) err_d = 1'b1;
            else           slot_push = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rstart) begin
                    araddr_d = raddr;
                    arlen_d  = req_len;
                    state_d  = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (io_master.arready) begin
                    cnt_d   = '0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (r_hs) begin
                    cnt_d = cnt_q + 8'd1;
                    if ((io_master.rresp != RESP_OKAY) || (io_master.rid != AXI_ID)) err_d = 1'b1;
                    if (io_master.rlast != (cnt_q == arlen_q)) err_d = 1'b1;
                    if (io_master.rlast) begin
                        if (slot_full) begin
                            araddr_d  = slot_addr;
                            arlen_d   = slot_len;
                            slot_pop  = 1'b1;
                            slot_push = rstart;
                            state_d   = ST_ADDR;
                        end else if (rstart) begin
                            araddr_d = raddr;
                            arlen_d  = req_len;
                            state_d  = ST_ADDR;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            araddr_q <= '0;
            arlen_q  <= '0;
            cnt_q    <= '0;
            rok_q    <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            araddr_q <= araddr_d;
            arlen_q  <= arlen_d;
            cnt_q    <= cnt_d;
            rok_q    <= rok_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    ysyx_25040111_req_slot u_slot (
        .clock  (clock),
        .reset  (reset),
        .push_i (slot_push),
        .pop_i  (slot_pop),
        .addr_i (raddr),
        .len_i  (req_len),
        .full_o (slot_full),
        .addr_o (slot_addr),
        .len_o  (slot_len)
    );

    assign io_master.arvalid = (state_q == ST_ADDR);
    assign io_master.araddr  = araddr_q;
    assign io_master.arid    = AXI_ID;
    assign io_master.arlen   = arlen_q;
    assign io_master.arsize  = SIZE_4B;
    assign io_master.arburst = BURST_INCR;
    assign io_master.rready  = (state_q == ST_DATA);

    assign rok   = rok_q;
    assign rdata = rdata_q;
    assign err   = err_q;
    assign busy  = (state_q != ST_IDLE) || slot_full;
endmodule

// File: tb/tb_ysyx_25040111_cache_axi_rd.sv
// Bench for the cache refill read responder: cycle tables, directed corner sequences,
// and a random request/AXI-slave run scored against a request-level model.
module tb_ysyx_25040111_cache_axi_rd;

    logic        clock = 1'b0;
    logic        reset;
    logic        rstart;
    logic [31:0] raddr;
    logic [7:0]  rlen;
    logic        rok;
    logic [31:0] rdata;
    logic        busy;
    logic        err;

    ysyx_25040111_cache_axi_rd_if bus ();

    ysyx_25040111_cache_axi_rd dut (
        .clock     (clock),
        .reset     (reset),
        .rstart    (rstart),
        .raddr     (raddr),
        .rlen      (rlen),
        .rok       (rok),
        .rdata     (rdata),
        .busy      (busy),
        .err       (err),
        .io_master (bus)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int rok_cnt  = 0;

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_t;

    ar_t ar_seen[$];
    logic        hs_q  = 1'b0;
    logic [31:0] hsd_q = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Every accepted R beat must reappear as exactly one rok one cycle later.
    always @(posedge clock) begin
        hs_q  <= bus.rvalid && bus.rready && !reset;
        hsd_q <= bus.rdata;
        if (bus.arvalid && bus.arready && !reset)
            ar_seen.push_back('{addr: bus.araddr, len: bus.arlen});
    end

    always @(negedge clock) begin
        chk("rok_pulse", rok, hs_q);
        if (hs_q) chk("rok_data", rdata, hsd_q);
        if (rok) rok_cnt++;
    end

    task automatic step();
        @(negedge clock);
        #1;
    endtask

    task automatic drive(input logic rs, input logic [31:0] a, input logic [7:0] l, input logic ar,
                         input logic rv, input logic [31:0] d, input logic lst, input logic [1:0] resp);
        rstart      = rs;
        raddr       = a;
        rlen        = l;
        bus.arready = ar;
        bus.rvalid  = rv;
        bus.rdata   = d;
        bus.rlast   = lst;
        bus.rresp   = resp;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic rs; logic [31:0] a; logic [7:0] l; logic ar;
        logic rv; logic [31:0] d; logic lst; logic [1:0] resp;
        logic e_arv; logic [31:0] e_aa; logic [7:0] e_al; logic e_rr;
        logic e_rok; logic [31:0] e_rd; logic e_busy; logic e_err;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic rs, input logic [31:0] a, input logic [7:0] l, input logic ar,
                       input logic rv, input logic [31:0] d, input logic lst, input logic [1:0] resp,
                       input logic e_arv, input logic [31:0] e_aa, input logic [7:0] e_al, input logic e_rr,
                       input logic e_rok, input logic [31:0] e_rd, input logic e_busy, input logic e_err);
        vq.push_back('{rs, a, l, ar, rv, d, lst, resp, e_arv, e_aa, e_al, e_rr, e_rok, e_rd, e_busy, e_err});
    endtask

    task automatic beat(input logic [31:0] d, input logic lst, input logic [1:0] resp);
        drive(0, 0, 0, 0, 1, d, lst, resp);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int base;
        int issued, completed, exp_beats, cur_beat;
        logic rv_on, cur_last, rs;
        logic [31:0] rd, a, tmp;
        logic [7:0] l;
        ar_t exp_req[$];
        logic [7:0] serve_q[$];

        bus.rid = 4'h0;
        do_reset();

        // Single beat, then 4-beat burst with AR and R backpressure.
        add(1, 32'h8000_0010, 0, 1, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0,  1, 32'h8000_0010, 0, 0,  0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 32'hDEAD_BEEF, 1, 0,  0, 0, 0, 1,  0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 32'hDEAD_BEEF, 0, 0);
        add(1, 32'h8000_0100, 3, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0100, 3, 0,  0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  1, 32'h8000_0100, 3, 0,  0, 0, 1, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0,  1, 32'h8000_0100, 3, 0,  0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 32'h11, 0, 0,  0, 0, 0, 1,  0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  1, 32'h11, 1, 0);
        add(0, 0, 0, 0, 1, 32'h22, 0, 0,  0, 0, 0, 1,  0, 0, 1, 0);
        add(0, 0, 0, 0, 1, 32'h33, 0, 0,  0, 0, 0, 1,  1, 32'h22, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1,  1, 32'h33, 1, 0);
        add(0, 0, 0, 0, 1, 32'h44, 1, 0,  0, 0, 0, 1,  0, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 32'h44, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            chk($sformatf("tbl%0d_arvalid", i), bus.arvalid, vq[i].e_arv);
            if (vq[i].e_arv) begin
                chk($sformatf("tbl%0d_araddr", i), bus.araddr, vq[i].e_aa);
                chk($sformatf("tbl%0d_arlen", i), bus.arlen, vq[i].e_al);
            end
            chk($sformatf("tbl%0d_rready", i), bus.rready, vq[i].e_rr);
            chk($sformatf("tbl%0d_rok", i), rok, vq[i].e_rok);
            if (vq[i].e_rok) chk($sformatf("tbl%0d_rdata", i), rdata, vq[i].e_rd);
            chk($sformatf("tbl%0d_busy", i), busy, vq[i].e_busy);
            chk($sformatf("tbl%0d_err", i), err, vq[i].e_err);
            drive(vq[i].rs, vq[i].a, vq[i].l, vq[i].ar, vq[i].rv, vq[i].d, vq[i].lst, vq[i].resp);
            step();
        end
        chk("ar_consts", {bus.arid, bus.arsize, bus.arburst}, {4'h0, 3'b010, 2'b01});

        // Pending request, then a dropped third request.
        do_reset();
        base = rok_cnt;
        drive(1, 32'h8000_0020, 1, 0, 0, 0, 0, 0); step();
        drive(0, 0, 0, 1, 0, 0, 0, 0); step();
        chk("pend_rready", bus.rready, 1);
        drive(1, 32'h8000_0040, 0, 0, 1, 32'hA0, 0, 0); step();
        chk("pend_busy", busy, 1);
        chk("pend_err_before", err, 0);
        drive(1, 32'h8000_0080, 0, 0, 0, 0, 0, 0); step();
        chk("pend_drop_err", err, 1);
        drive(0, 0, 0, 0, 1, 32'hA1, 1, 0); step();
        chk("pend_ar2_valid", bus.arvalid, 1);
        chk("pend_ar2_addr", bus.araddr, 32'h8000_0040);
        chk("pend_ar2_len", bus.arlen, 0);
        drive(0, 0, 0, 1, 0, 0, 0, 0); step();
        beat(32'hB0, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("pend_no_ar3", bus.arvalid, 0);
        chk("pend_idle", busy, 0);
        chk("pend_err_sticky", err, 1);
        chk("pend_rok_count", rok_cnt - base, 3);

        // Error response on beat 2: all beats still delivered, err sticks.
        do_reset();
        base = rok_cnt;
        drive(1, 32'h8000_0200, 3, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 1, 0, 0, 0, 0); step();
        for (int i = 0; i < 4; i++) begin
            beat(32'h100 + i, i == 3, (i == 2) ? 2'b10 : 2'b00);
            if (i == 1) chk("resp_err_before", err, 0);
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("resp_rok_count", rok_cnt - base, 4);
        chk("resp_err", err, 1);
        step(); step(); step();
        chk("resp_err_sticky", err, 1);

        // Early rlast on beat 1 of a 4-beat burst.
        do_reset();
        base = rok_cnt;
        drive(1, 32'h8000_0300, 3, 1, 0, 0, 0, 0); step();
        drive(0, 0, 0, 1, 0, 0, 0, 0); step();
        beat(32'hC0, 0, 0);
        beat(32'hC1, 1, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("early_rready", bus.rready, 0);
        chk("early_busy", busy, 0);
        chk("early_err", err, 1);
        chk("early_rok_count", rok_cnt - base, 2);

        // Clamped length, then reset mid-burst, then a clean request.
        do_reset();
        drive(1, 32'h8000_0400, 20, 0, 0, 0, 0, 0); step();
        chk("clamp_arlen", bus.arlen, 15);
        chk("clamp_err", err, 1);
        drive(0, 0, 0, 1, 0, 0, 0, 0); step();
        beat(32'h55, 0, 0);
        reset = 1'b1;
        drive(0, 0, 0, 0, 1, 32'h66, 0, 0); step();
        reset = 1'b0;
        chk("rst_arvalid", bus.arvalid, 0);
        chk("rst_rready", bus.rready, 0);
        chk("rst_rok", rok, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        drive(1, 32'h8000_0500, 0, 0, 0, 0, 0, 0); step();
        chk("rst_new_arvalid", bus.arvalid, 1);
        chk("rst_new_araddr", bus.araddr, 32'h8000_0500);
        drive(0, 0, 0, 1, 0, 0, 0, 0); step();
        beat(32'h77, 1, 0);
        chk("rst_new_rok", rok, 1);
        chk("rst_new_rdata", rdata, 32'h77);
        chk("rst_new_err", err, 0);

        // Random traffic against a request-level model.
        do_reset();
        ar_seen.delete();
        base = rok_cnt;
        issued = 0; completed = 0; exp_beats = 0; cur_beat = 0;
        rv_on = 1'b0; cur_last = 1'b0; rd = '0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (hs_q) begin
                if (cur_last) begin
                    void'(serve_q.pop_front());
                    cur_beat = 0;
                    completed++;
                end else begin
                    cur_beat++;
                end
                rv_on = 1'b0;
            end
            while (ar_seen.size() > 0) begin
                ar_t got, want;
                got = ar_seen.pop_front();
                if (exp_req.size() == 0) begin
                    chk("rnd_ar_unexpected", got.addr, 32'hFFFF_FFFF);
                end else begin
                    want = exp_req.pop_front();
                    chk("rnd_ar_addr", got.addr, want.addr);
                    chk("rnd_ar_len", {24'h0, got.len}, {24'h0, want.len});
                end
                serve_q.push_back(got.len);
            end
            chk("rnd_busy", busy, (issued != completed));
            if (cyc >= 800 && issued == completed) break;

            rs = 1'b0; a = '0; l = '0;
            if (cyc < 800 && (issued - completed) < 2 && $urandom_range(0, 3) == 0) begin
                tmp = $urandom();
                a = {tmp[31:2], 2'b00};
                l = 8'($urandom_range(0, 7));
                rs = 1'b1;
                exp_req.push_back('{addr: a, len: l});
                issued++;
                exp_beats += int'(l) + 1;
            end
            if (!rv_on && serve_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                rv_on = 1'b1;
                rd = $urandom();
                cur_last = (cur_beat == int'(serve_q[0]));
            end
            drive(rs, a, l, 1'($urandom_range(0, 1)), rv_on, rd, rv_on && cur_last, 2'b00);
            step();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); step();
        chk("rnd_drained", (issued == completed), 1);
        chk("rnd_requests_nonzero", (issued > 3), 1);
        chk("rnd_ar_all_issued", exp_req.size(), 0);
        chk("rnd_rok_count", rok_cnt - base, exp_beats);
        chk("rnd_err", err, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
